// File: rtl/stage_arbiter.sv
// stage_arbiter: two-requester packet arbiter sharing one registered output stage
// Ports: clk/rst (sync active-high); req0_*/req1_* valid-ready-data-last inputs;
// out_* registered valid-ready-data-last-src output; pkt_cnt counts drained packets.
module stage_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_src,
  output logic [15:0]      pkt_cnt
);
  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
  state_t state_q, state_d;
  logic prio_q, prio_d, valid_q, last_q, src_q;
  logic [WIDTH-1:0] data_q, in_data;
  logic [15:0] cnt_q;
  logic can_load, g0, g1, x0, x1, xfer, in_last;
  always_comb begin
    can_load = !valid_q | out_ready;
    // A lock owns the stage outright; in IDLE the pointer only breaks ties
    g0 = (state_q == LOCK0) | ((state_q == IDLE) & req0_valid & (!req1_valid | !prio_q));
    g1 = (state_q == LOCK1) | ((state_q == IDLE) & req1_valid & (!req0_valid | prio_q));
    req0_ready = !rst & can_load & g0;
    req1_ready = !rst & can_load & g1;
    x0 = req0_ready & req0_valid;
    x1 = req1_ready & req1_valid;
    xfer = x0 | x1;
    in_data = x1 ? req1_data : req0_data;
    in_last = x1 ? req1_last : req0_last;
    state_d = !xfer ? state_q : in_last ? IDLE : x1 ? LOCK1 : LOCK0;
    prio_d = (xfer & in_last) ? !x1 : prio_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      src_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      if (xfer) begin
        valid_q <= 1'b1;
        data_q  <= in_data;
        last_q  <= in_last;
        src_q   <= x1;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
      if (valid_q & out_ready & last_q) cnt_q <= cnt_q + 16'd1;
    end
  end
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_src   = src_q;
  assign pkt_cnt   = cnt_q;
endmodule

// File: tb/tb_stage_arbiter.sv
// tb_stage_arbiter: directed self-checking bench for stage_arbiter
module tb_stage_arbiter;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req0_last = 0, req1_valid = 0, req1_last = 0, out_ready = 0;
  logic [7:0] req0_data = 0, req1_data = 0;
  logic req0_ready, req1_ready, out_valid, out_last, out_src;
  logic [7:0] out_data;
  logic [15:0] pkt_cnt;
  int checks = 0, errors = 0;
  stage_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_src(out_src), .pkt_cnt(pkt_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v0, input logic [7:0] d0, input logic l0,
                       input logic v1, input logic [7:0] d1, input logic l1, input logic ordy);
    req0_valid = v0; req0_data = d0; req0_last = l0;
    req1_valid = v1; req1_data = d1; req1_last = l1;
    out_ready = ordy;
    #1;
  endtask
  initial begin
    drive(1, 8'h11, 1, 1, 8'h22, 1, 1);
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_src", out_src, 0);
    chk("rst_cnt", pkt_cnt, 0);
    rst = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("alt_rdy0", req0_ready, (i % 2) == 0);
      chk("alt_rdy1", req1_ready, (i % 2) == 1);
      tick();
      chk("alt_valid", out_valid, 1);
      chk("alt_src", out_src, i % 2);
      chk("alt_data", out_data, (i % 2) ? 8'h22 : 8'h11);
      chk("alt_cnt", pkt_cnt, i);
      #1;
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("drain_valid", out_valid, 0);
    chk("drain_cnt", pkt_cnt, 4);
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'hA0 + 8'(i), i == 2, 1, 8'h33, 1, 1);
      chk("lock_rdy0", req0_ready, 1);
      chk("lock_rdy1", req1_ready, 0);
      tick();
      chk("lock_src", out_src, 0);
      chk("lock_data", out_data, 8'hA0 + 8'(i));
      chk("lock_last", out_last, i == 2);
    end
    chk("lock_cnt", pkt_cnt, 4);
    drive(0, 0, 0, 1, 8'h33, 1, 1);
    chk("after_rdy1", req1_ready, 1);
    tick();
    chk("after_src", out_src, 1);
    chk("after_data", out_data, 8'h33);
    chk("after_cnt", pkt_cnt, 5);
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("drain2_cnt", pkt_cnt, 6);
    drive(1, 8'h5C, 1, 0, 0, 0, 1);
    tick();
    chk("stall_load", out_data, 8'h5C);
    drive(1, 8'h5D, 1, 1, 8'h66, 1, 0);
    for (int i = 0; i < 4; i++) begin
      chk("stall_rdy0", req0_ready, 0);
      chk("stall_rdy1", req1_ready, 0);
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 8'h5C);
      chk("stall_last", out_last, 1);
      chk("stall_src", out_src, 0);
      chk("stall_cnt", pkt_cnt, 6);
    end
    drive(1, 8'h5D, 1, 1, 8'h66, 1, 1);
    chk("rel_rdy1", req1_ready, 1);
    chk("rel_rdy0", req0_ready, 0);
    tick();
    chk("rel_cnt", pkt_cnt, 7);
    chk("rel_data", out_data, 8'h66);
    chk("rel_src", out_src, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("drain3_cnt", pkt_cnt, 8);
    drive(0, 0, 0, 1, 8'hB0, 0, 1);
    tick();
    chk("mid_data", out_data, 8'hB0);
    drive(1, 8'hC0, 1, 1, 8'hB1, 0, 1);
    rst = 1;
    #1;
    chk("mid_rst_rdy0", req0_ready, 0);
    chk("mid_rst_rdy1", req1_ready, 0);
    tick();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_cnt", pkt_cnt, 0);
    rst = 0;
    #1;
    chk("post_rdy0", req0_ready, 1);
    chk("post_rdy1", req1_ready, 0);
    tick();
    chk("post_src", out_src, 0);
    chk("post_data", out_data, 8'hC0);
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("wrap_pre", pkt_cnt, 1);
    drive(1, 8'h77, 1, 0, 0, 0, 1);
    for (int i = 0; i < 65535; i++) tick();
    chk("wrap_ffff", pkt_cnt, 16'hFFFF);
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("wrap_zero", pkt_cnt, 16'h0000);
    chk("wrap_valid", out_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stage_arbiter.md
STAGE_ARBITER -- requirements
Module: stage_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, data width of every data port.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: req0_valid  input  1  requester 0 beat valid.
REQ-005 Port: req0_data  input  WIDTH  requester 0 beat data.
REQ-006 Port: req0_last  input  1  requester 0 final beat of packet.
REQ-007 Port: req0_ready  output  1  requester 0 beat accepted when valid and ready are both 1.
REQ-008 Port: req1_valid, req1_data, req1_last, req1_ready  same directions, widths and meaning as REQ-004..007, for requester 1.
REQ-009 Port: out_valid  output  1  output register holds a beat.
REQ-010 Port: out_ready  input  1  downstream accepts the beat.
REQ-011 Port: out_data  output  WIDTH  registered beat data.
REQ-012 Port: out_last  output  1  registered last flag.
REQ-013 Port: out_src  output  1  requester index of registered beat.
REQ-014 Port: pkt_cnt  output  16  completed packets forwarded downstream.

Function
REQ-015 Block SHALL share one registered output stage between two requesters; packets of one or more beats SHALL never interleave.
REQ-016 Internal load enable: can_load = !out_valid | out_ready.
REQ-017 FSM states: IDLE, LOCK0, LOCK1; one-bit priority pointer prio (0 = requester 0 preferred).
REQ-018 IDLE: grant goes to the only valid requester; if both valid, grant = prio; reqN_ready = can_load & granted(N); non-granted ready = 0.
REQ-019 In IDLE, ready MAY depend combinationally on req*_valid; in LOCKn, reqN_ready = can_load and the other ready SHALL be 0 regardless of valid.
REQ-020 Transfer from N with last=0: IDLE -> LOCKn (or remain LOCKn); prio unchanged.
REQ-021 Transfer from N with last=1: next state IDLE; prio set to !N.
REQ-022 No transfer: state and prio hold.
REQ-023 Latency: beat accepted at edge k SHALL be on out_data/out_last/out_src with out_valid=1 after edge k (one cycle).
REQ-024 out_valid, out_data, out_last, out_src SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 out_valid clears after edge where out_valid & out_ready and no new transfer; back-to-back transfer with simultaneous drain SHALL sustain one beat per cycle.
REQ-026 pkt_cnt increments by 1 on each edge where out_valid & out_ready & out_last; wraps 0xFFFF -> 0x0000.
REQ-027 out_data SHALL not change when no transfer occurs (no X, no bubble data write).

Reset
REQ-028 When rst=1 at an edge: state=IDLE, prio=0, out_valid=0, out_data=0, out_last=0, out_src=0, pkt_cnt=0.
REQ-029 Reset mid-packet SHALL drop the held beat and the lock; no beat accepted in the reset cycle; req*_ready SHALL be 0 while rst=1.
REQ-030 First cycle after reset deassertion SHALL arbitrate normally from IDLE.

Verification
REQ-031 Both valid, single-beat (last=1), data 0x11/0x22, out_ready=1 -> out sequence src 0,1,0,1 alternating, one beat/cycle, pkt_cnt +1 per cycle.
REQ-032 Req0 sends 3-beat packet 0xA0,0xA1,0xA2(last) while req1 valid throughout -> req1_ready=0 for all three beats; req1 granted next; out_src 0,0,0,1.
REQ-033 out_ready=0 for 4 cycles with out_valid=1, data 0x5C -> out_* held stable, both req*_ready=0; release -> 0x5C drains, next beat follows one cycle later.
REQ-034 pkt_cnt preset by sending 65535 packets, one more last beat drained -> pkt_cnt=0x0000.
REQ-035 rst=1 during beat 2 of req1 4-beat packet -> out_valid=0, state IDLE, prio=0; after release, with both valid, req0 granted first.
